// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller:
// FSM states, ALU operations, opcodes and datapath mux codes.
package mc_controller_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    localparam logic [3:0] ALU_CTRL_ADD  = 4'd0;
    localparam logic [3:0] ALU_CTRL_SUB  = 4'd1;
    localparam logic [3:0] ALU_CTRL_SLL  = 4'd2;
    localparam logic [3:0] ALU_CTRL_SLT  = 4'd3;
    localparam logic [3:0] ALU_CTRL_SLTU = 4'd4;
    localparam logic [3:0] ALU_CTRL_XOR  = 4'd5;
    localparam logic [3:0] ALU_CTRL_SRL  = 4'd6;
    localparam logic [3:0] ALU_CTRL_SRA  = 4'd7;
    localparam logic [3:0] ALU_CTRL_OR   = 4'd8;
    localparam logic [3:0] ALU_CTRL_AND  = 4'd9;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] PC_PLUS4 = 2'b00;
    localparam logic [1:0] PC_ALU   = 2'b01;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    localparam logic [1:0] SRCA_RS1  = 2'b00;
    localparam logic [1:0] SRCA_ZERO = 2'b01;
    localparam logic [1:0] SRCA_PC   = 2'b10;

    localparam logic [1:0] SRCB_RS2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;

    localparam logic [4:0] IMM_NONE = 5'b00000;
    localparam logic [4:0] IMM_I    = 5'b10000;
    localparam logic [4:0] IMM_S    = 5'b01000;
    localparam logic [4:0] IMM_B    = 5'b00100;
    localparam logic [4:0] IMM_U    = 5'b00010;
    localparam logic [4:0] IMM_J    = 5'b00001;

    function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                          input logic alt);
        logic [3:0] r;
        r = ALU_CTRL_ADD;
        unique case (f3)
            3'b000:  r = alt ? ALU_CTRL_SUB : ALU_CTRL_ADD;
            3'b001:  r = ALU_CTRL_SLL;
            3'b010:  r = ALU_CTRL_SLT;
            3'b011:  r = ALU_CTRL_SLTU;
            3'b100:  r = ALU_CTRL_XOR;
            3'b101:  r = alt ? ALU_CTRL_SRA : ALU_CTRL_SRL;
            3'b110:  r = ALU_CTRL_OR;
            default: r = ALU_CTRL_AND;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU operation decode and illegal-instruction detection
// from the IR fields and the current controller state.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    input  state_e     state_i,
    output logic [3:0] aluctrl_o,
    output logic       bunsigned_o,
    output logic       illegal_o
);

    logic [3:0] op_alu;
    logic       br_uns;
    logic       f7_ok;
    logic       alt_ok;

    assign f7_ok  = (funct7_i == F7_BASE) || (funct7_i == F7_ALT);
    assign alt_ok = (funct3_i == 3'b000) || (funct3_i == 3'b101);

    always_comb begin
        op_alu    = ALU_CTRL_ADD;
        br_uns    = 1'b0;
        illegal_o = 1'b0;
        unique case (opcode_i)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
            OP_LOAD, OP_STORE: op_alu = ALU_CTRL_ADD;
            OP_BRANCH: begin
                br_uns = funct3_i[2] & funct3_i[1];
                if (!funct3_i[2])
                    op_alu = ALU_CTRL_SUB;
                else
                    op_alu = funct3_i[1] ? ALU_CTRL_SLTU : ALU_CTRL_SLT;
            end
            OP_IMM: begin
                // funct7 is immediate data except on shifts
                op_alu = alu_op(funct3_i,
                                funct3_i == 3'b101 && funct7_i[5]);
                if (funct3_i == 3'b001)
                    illegal_o = funct7_i != F7_BASE;
                else if (funct3_i == 3'b101)
                    illegal_o = !f7_ok;
            end
            OP_OP: begin
                op_alu    = alu_op(funct3_i, funct7_i[5]);
                illegal_o = !f7_ok || (funct7_i == F7_ALT && !alt_ok);
            end
            default: illegal_o = 1'b1;
        endcase
    end

    always_comb begin
        aluctrl_o   = ALU_CTRL_ADD;
        bunsigned_o = 1'b0;
        if (state_i == S_EXEC || state_i == S_WB)
            aluctrl_o = op_alu;
        if (state_i == S_EXEC)
            bunsigned_o = br_uns;
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM: sequences fetch/decode/exec/mem/wb
// over a shared ALU and a unified memory with a bounded handshake.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel_data,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       regwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [3:0] aluctrl,
    output logic [4:0] immctrl,
    output logic       bunsigned,
    output logic       lunsigned,
    output logic       retire,
    output logic       halted,
    output logic [2:0] state
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          illegal;
    logic          taken;
    logic [1:0]    fmt_a, fmt_b;
    logic [4:0]    fmt_imm;
    logic          is_branch, is_jump, is_load, is_store;

    assign is_branch = opcode == OP_BRANCH;
    assign is_jump   = opcode == OP_JAL || opcode == OP_JALR;
    assign is_load   = opcode == OP_LOAD;
    assign is_store  = opcode == OP_STORE;
    assign state     = state_q;

    mc_aludec u_aludec (
        .opcode_i    (opcode),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .state_i     (state_q),
        .aluctrl_o   (aluctrl),
        .bunsigned_o (bunsigned),
        .illegal_o   (illegal)
    );

    always_comb begin
        fmt_a   = SRCA_RS1;
        fmt_b   = SRCB_IMM;
        fmt_imm = IMM_I;
        unique case (opcode)
            OP_LUI:    begin fmt_a = SRCA_ZERO; fmt_imm = IMM_U; end
            OP_AUIPC:  begin fmt_a = SRCA_PC;   fmt_imm = IMM_U; end
            OP_JAL:    begin fmt_a = SRCA_PC;   fmt_imm = IMM_J; end
            OP_BRANCH: begin fmt_b = SRCB_RS2;  fmt_imm = IMM_B; end
            OP_STORE:  fmt_imm = IMM_S;
            OP_OP:     begin fmt_b = SRCB_RS2;  fmt_imm = IMM_NONE; end
            default:   fmt_imm = IMM_I;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        unique case (funct3)
            3'b000:         taken = zero;
            3'b001:         taken = !zero;
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default:        taken = 1'b0;
        endcase
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_sel_data = 1'b0;
        irwrite      = 1'b0;
        pcwrite      = 1'b0;
        pcsrc        = PC_PLUS4;
        regwrite     = 1'b0;
        resultsrc    = RES_ALU;
        alusrca      = SRCA_RS1;
        alusrcb      = SRCB_RS2;
        immctrl      = IMM_NONE;
        lunsigned    = 1'b0;
        retire       = 1'b0;
        halted       = 1'b0;
        state_d      = state_q;
        unique case (state_q)
            S_FETCH: begin
                // held quiet while reset is low
                mem_req = reset;
                irwrite = reset & mem_ready;
                if (mem_ready)
                    state_d = S_DECODE;
                else if (cnt_q == LIMIT)
                    state_d = S_HALT;
            end
            S_DECODE: begin
                if (is_branch) begin
                    alusrca = SRCA_PC;
                    alusrcb = SRCB_IMM;
                    immctrl = IMM_B;
                end
                state_d = illegal ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                alusrca = fmt_a;
                alusrcb = fmt_b;
                immctrl = fmt_imm;
                if (is_branch) begin
                    pcwrite = 1'b1;
                    pcsrc   = taken ? PC_ALU : PC_PLUS4;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (is_jump) begin
                    regwrite  = 1'b1;
                    resultsrc = RES_PC4;
                    pcwrite   = 1'b1;
                    pcsrc     = PC_ALU;
                    retire    = 1'b1;
                    state_d   = S_FETCH;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                mem_req      = 1'b1;
                mem_sel_data = 1'b1;
                mem_we       = is_store;
                lunsigned    = funct3[2];
                if (mem_ready) begin
                    if (is_store) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == LIMIT) begin
                    state_d = S_HALT;
                end
            end
            S_WB: begin
                alusrca   = fmt_a;
                alusrcb   = fmt_b;
                immctrl   = fmt_imm;
                regwrite  = 1'b1;
                resultsrc = is_load ? RES_MEM : RES_ALU;
                pcwrite   = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_req && !mem_ready)
            cnt_d = cnt_q + CW'(1);
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM))
            cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle checks of state
// sequencing, control outputs, timeout and reset behaviour.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic [6:0] funct7 = 7'd0;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_sel_data, irwrite, pcwrite;
    logic [1:0] pcsrc, resultsrc, alusrca, alusrcb;
    logic       regwrite, bunsigned, lunsigned, retire, halted;
    logic [3:0] aluctrl;
    logic [4:0] immctrl;
    logic [2:0] state;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [6:0] LUI = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL = 7'b1101111, BR = 7'b1100011;
    localparam logic [6:0] LD = 7'b0000011, ST = 7'b0100011;
    localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011;
    localparam logic [6:0] FENCE = 7'b0001111;

    always #5 clk = ~clk;

    mc_controller #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7(funct7), .zero(zero), .lt(lt), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel_data(mem_sel_data),
        .irwrite(irwrite), .pcwrite(pcwrite), .pcsrc(pcsrc),
        .regwrite(regwrite), .resultsrc(resultsrc), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluctrl(aluctrl), .immctrl(immctrl),
        .bunsigned(bunsigned), .lunsigned(lunsigned), .retire(retire),
        .halted(halted), .state(state)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3,
                          input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst mem_req", mem_req, 0);
        check("rst irwrite", irwrite, 0);
        check("rst state", state, 0);
        check("rst halted", halted, 0);
        @(negedge clk);
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        check("rel mem_req", mem_req, 1);
        check("rel state", state, 0);
    endtask

    task automatic fetch(input string tag);
        mem_ready = 1'b1;
        #1;
        check({tag, " F state"}, state, 0);
        check({tag, " F irwrite"}, irwrite, 1);
        check({tag, " F sel"}, mem_sel_data, 0);
        tick();
    endtask

    task automatic run_alu(input string tag, input logic [6:0] op,
                           input logic [2:0] f3, input logic [6:0] f7,
                           input logic [3:0] ea, input logic [1:0] sa,
                           input logic [1:0] sb, input logic [4:0] im);
        set_ir(op, f3, f7);
        fetch(tag);
        #1;
        check({tag, " D state"}, state, 1);
        check({tag, " D mem_req"}, mem_req, 0);
        tick();
        #1;
        check({tag, " E state"}, state, 2);
        check({tag, " E aluctrl"}, aluctrl, ea);
        check({tag, " E srca"}, alusrca, sa);
        check({tag, " E srcb"}, alusrcb, sb);
        check({tag, " E imm"}, immctrl, im);
        check({tag, " E retire"}, retire, 0);
        tick();
        #1;
        check({tag, " W state"}, state, 4);
        check({tag, " W retire"}, retire, 1);
        check({tag, " W regwrite"}, regwrite, 1);
        check({tag, " W resultsrc"}, resultsrc, 0);
        check({tag, " W aluctrl"}, aluctrl, ea);
        check({tag, " W srcb"}, alusrcb, sb);
        tick();
        check({tag, " next state"}, state, 0);
    endtask

    task automatic run_br(input string tag, input logic [2:0] f3,
                          input logic z, input logic l,
                          input logic [1:0] epc, input logic [3:0] ea,
                          input logic eu);
        set_ir(BR, f3, 7'd0);
        zero = z;
        lt = l;
        fetch(tag);
        #1;
        check({tag, " D srca"}, alusrca, 2);
        check({tag, " D srcb"}, alusrcb, 1);
        check({tag, " D imm"}, immctrl, 5'b00100);
        tick();
        #1;
        check({tag, " E state"}, state, 2);
        check({tag, " E pcsrc"}, pcsrc, epc);
        check({tag, " E pcwrite"}, pcwrite, 1);
        check({tag, " E retire"}, retire, 1);
        check({tag, " E aluctrl"}, aluctrl, ea);
        check({tag, " E bunsigned"}, bunsigned, eu);
        check({tag, " E regwrite"}, regwrite, 0);
        tick();
        check({tag, " next state"}, state, 0);
    endtask

    task automatic lat(input string tag, input logic [6:0] op,
                       input logic [2:0] f3, input int exp,
                       input logic elu);
        int n;
        n = 0;
        set_ir(op, f3, 7'd0);
        mem_ready = 1'b1;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            #1;
            if (state == 3'd3)
                check({tag, " lunsigned"}, lunsigned, elu);
            if (retire)
                n = i;
            tick();
        end
        check({tag, " latency"}, n, exp);
    endtask

    task automatic run_illegal(input string tag, input logic [6:0] op,
                               input logic [2:0] f3,
                               input logic [6:0] f7);
        set_ir(op, f3, f7);
        fetch(tag);
        #1;
        check({tag, " D regwrite"}, regwrite, 0);
        tick();
        #1;
        check({tag, " halt state"}, state, 5);
        check({tag, " halted"}, halted, 1);
        check({tag, " mem_req"}, mem_req, 0);
        tick();
        #1;
        check({tag, " still halt"}, state, 5);
        check({tag, " no irwrite"}, irwrite, 0);
        do_reset();
    endtask

    initial begin
        do_reset();

        run_alu("addi", OPI, 3'b000, 7'd0, 4'd0, 2'b00, 2'b01, 5'b10000);
        run_alu("addi hi", OPI, 3'b000, 7'b0100000, 4'd0, 2'b00, 2'b01,
                5'b10000);
        run_alu("srai", OPI, 3'b101, 7'b0100000, 4'd7, 2'b00, 2'b01,
                5'b10000);
        run_alu("sub", OPR, 3'b000, 7'b0100000, 4'd1, 2'b00, 2'b00,
                5'b00000);
        run_alu("sltu", OPR, 3'b011, 7'd0, 4'd4, 2'b00, 2'b00, 5'b00000);
        run_alu("lui", LUI, 3'b000, 7'd0, 4'd0, 2'b01, 2'b01, 5'b00010);
        run_alu("auipc", AUIPC, 3'b000, 7'd0, 4'd0, 2'b10, 2'b01,
                5'b00010);

        // LW with three wait cycles in MEM
        set_ir(LD, 3'b010, 7'd0);
        fetch("lw");
        tick();
        #1;
        check("lw E imm", immctrl, 5'b10000);
        check("lw E srcb", alusrcb, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            #1;
            check("lw M state", state, 3);
            check("lw M req", mem_req, 1);
            check("lw M sel", mem_sel_data, 1);
            check("lw M we", mem_we, 0);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("lw M last req", mem_req, 1);
        check("lw M lunsigned", lunsigned, 0);
        check("lw M retire", retire, 0);
        tick();
        #1;
        check("lw W state", state, 4);
        check("lw W resultsrc", resultsrc, 1);
        check("lw W retire", retire, 1);
        tick();

        run_br("beq", 3'b000, 1'b1, 1'b0, 2'b01, 4'd1, 1'b0);
        run_br("bne", 3'b001, 1'b1, 1'b0, 2'b00, 4'd1, 1'b0);
        run_br("bltu", 3'b110, 1'b0, 1'b1, 2'b01, 4'd4, 1'b1);
        run_br("bge", 3'b101, 1'b0, 1'b1, 2'b00, 4'd3, 1'b0);

        // JAL executes the link and jump in EXEC
        set_ir(JAL, 3'b000, 7'd0);
        fetch("jal");
        tick();
        #1;
        check("jal E regwrite", regwrite, 1);
        check("jal E resultsrc", resultsrc, 2);
        check("jal E pcsrc", pcsrc, 1);
        check("jal E srca", alusrca, 2);
        check("jal E imm", immctrl, 5'b00001);
        check("jal E retire", retire, 1);
        tick();

        // SW zero-wait
        set_ir(ST, 3'b010, 7'd0);
        fetch("sw");
        tick();
        tick();
        mem_ready = 1'b1;
        #1;
        check("sw M state", state, 3);
        check("sw M we", mem_we, 1);
        check("sw M sel", mem_sel_data, 1);
        check("sw M pcwrite", pcwrite, 1);
        check("sw M pcsrc", pcsrc, 0);
        check("sw M retire", retire, 1);
        check("sw M regwrite", regwrite, 0);
        tick();
        check("sw next state", state, 0);

        lat("jal", JAL, 3'b000, 3, 1'b0);
        lat("add", OPR, 3'b000, 4, 1'b0);
        lat("sw", ST, 3'b010, 4, 1'b0);
        lat("lbu", LD, 3'b100, 5, 1'b1);

        run_illegal("fence", FENCE, 3'b000, 7'd0);
        run_illegal("sll alt", OPR, 3'b001, 7'b0100000);
        run_illegal("mul", OPR, 3'b000, 7'b0000001);
        run_illegal("slli bad", OPI, 3'b001, 7'b0100000);

        // fetch timeout: 16 unanswered cycles then HALT
        for (int i = 0; i < 16; i++) begin
            mem_ready = 1'b0;
            #1;
            check("to state", state, 0);
            check("to req", mem_req, 1);
            tick();
        end
        #1;
        check("to halt state", state, 5);
        check("to halted", halted, 1);
        check("to req dropped", mem_req, 0);
        mem_ready = 1'b1;
        tick();
        #1;
        check("to stays halted", state, 5);
        check("to ready ignored", irwrite, 0);
        do_reset();

        // ready on the final permitted cycle completes the fetch
        for (int i = 0; i < 15; i++) begin
            mem_ready = 1'b0;
            tick();
        end
        mem_ready = 1'b1;
        set_ir(OPI, 3'b000, 7'd0);
        #1;
        check("lim irwrite", irwrite, 1);
        tick();
        #1;
        check("lim decode", state, 1);
        do_reset();

        // reset during a store's MEM cycle aborts it
        set_ir(ST, 3'b010, 7'd0);
        fetch("abort");
        tick();
        tick();
        mem_ready = 1'b0;
        #1;
        check("abort M we", mem_we, 1);
        reset = 1'b0;
        #1;
        check("abort we drop", mem_we, 0);
        check("abort pcwrite", pcwrite, 0);
        check("abort req", mem_req, 0);
        check("abort state", state, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort rel state", state, 0);
        check("abort rel req", mem_req, 1);
        check("abort rel retire", retire, 0);
        tick();
        #1;
        check("abort no retire", retire, 0);
        check("abort fetch", state, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
